keypad_matrix_responder: RTL and testbench
==========================================

Name: keypad_matrix_responder

Overview:
- Synthesizable 4x4 keypad emulator. It is the responder side of the row-scan/column-sense keypad interface that our keypad scanner drives.
- Its input is the scanner's keypadRow drive; its output is keypadCol. A key-press command sequences press, optional contact bounce, hold, and release.
- Used in the self-test build, which replaces the physical keypad, so the guess-entry path can be exercised without a human.

Parameters:
- HOLD_W, 16, width of the cmd_hold cycle count.
- BOUNCE_TOGGLES, 4, number of open/closed pairs per bounce burst (T); must be at least 1.
- BOUNCE_LEN, 3, cycles per bounce phase (L); must be at least 1.

Ports:
- clk  in  1  system clock; the single clock domain.
- rst  in  1  reset; synchronous, active-high.
- cmd_valid  in  1  a press command is offered.
- cmd_ready  out  1  the responder accepts a command this cycle.
- cmd_key  in  4  key code; [3:2] = row index, [1:0] = column index.
- cmd_hold  in  HOLD_W  number of cycles the contact is held steadily closed.
- cmd_bounce  in  1  1 = insert a bounce burst on press and on release.
- keypadRow  in  4  scanner row drive, active-low; row r is selected when keypadRow[r]==0.
- keypadCol  out  4  column sense, active-low; idle value 4'b1111.
- busy  out  1  a command is in progress (state is not IDLE).
- done  out  1  single-cycle pulse at the end of a command.
- contact  out  1  current state of the emulated switch contact (debug).

Behaviour:
- Reset (synchronous, active-high): state=IDLE, contact=0, done=0, busy=0, latched key=0. keypadCol reads 4'b1111 from the first cycle after the reset edge. Reset mid-command aborts it immediately: no done pulse, and the command is discarded.
- keypadCol is combinational from keypadRow and the registered contact/key:
  - keypadCol[c] = 0 iff contact==1, c==key_col, and keypadRow[key_row]==0; otherwise 1.
  - Several rows low at once: the column still asserts if the key's row is among them.
  - All rows high: output is 4'b1111.
- Handshake:
  - cmd_ready = (state==IDLE).
  - A command is accepted on an edge where cmd_valid && cmd_ready; cmd_key, cmd_hold and cmd_bounce are latched on that edge.
  - cmd_valid is ignored while busy; no queueing.
- State machine:
  - IDLE: contact=0. On accept, go to PRESS_BOUNCE if cmd_bounce, else HOLD.
  - PRESS_BOUNCE: 2T phases of L cycles each. Phase p has contact = (p even), so the burst starts closed and ends open. Then go to HOLD.
  - HOLD: contact=1 for max(cmd_hold,1) cycles; cmd_hold=0 is treated as 1. Then go to RELEASE_BOUNCE if the latched bounce bit is set, else DONE.
  - RELEASE_BOUNCE: 2T phases of L cycles. Phase p has contact = (p odd), so the burst starts open and ends closed. Then go to DONE.
  - DONE: contact=0, done=1, busy=1 for exactly one cycle. Then go to IDLE.
- Latency:
  - The contact first closes in the cycle after the accept edge.
  - Total busy cycles = max(H,1) + 1 without bounce, and max(H,1) + 4TL + 1 with bounce.
  - A new command can be accepted in the first IDLE cycle after DONE.
- Counters:
  - The hold counter is HOLD_W bits and loads cmd_hold; it never wraps, including at cmd_hold = all-ones.
  - The phase counter is ceil(log2(2T)) bits; the cycle-within-phase counter is ceil(log2(L)) bits.
- contact is registered and changes only on clk edges.

Decomposition:
- Shared package keypad_pkg holds:
  - the state enum (IDLE, PRESS_BOUNCE, HOLD, RELEASE_BOUNCE, DONE);
  - KEYPAD_IDLE = 4'b1111;
  - key-code field positions (row [3:2], column [1:0]).
  The scanner reuses KEYPAD_IDLE and the field positions.
- One sub-module, keypad_bounce_gen:
  - Inputs: start, polarity (press/release).
  - Outputs: the contact level and a finish pulse.
  - Holds the phase and cycle counters, and is instantiated once.
- The parent keeps the FSM, the hold counter, the latching, and the column logic.

Test Plan:
1. Reset then idle: keypadRow cycles 1110/1101/1011/0111 -> keypadCol==1111 throughout; cmd_ready=1; busy=0.
2. Command cmd_key=4'b0110 (row 1, col 2), cmd_hold=5, cmd_bounce=0 -> contact=1 for cycles 1..5 after accept. keypadCol==1011 only while keypadRow==1101, else 1111. done pulses in cycle 6; cmd_ready returns in cycle 7.
3. Same key with cmd_bounce=1, T=4, L=3 -> contact sequence 1,0 repeated (3 cycles per phase, 24 cycles), then 5 cycles closed, then 0,1 repeated for 24 cycles, then DONE. busy lasts exactly 54 cycles.
4. cmd_hold=0 with a second cmd_valid asserted while busy -> hold lasts 1 cycle; the second command is ignored until cmd_ready, then accepted on its first IDLE cycle.
5. Assert rst mid-HOLD -> next cycle: contact=0, keypadCol=1111, no done pulse, cmd_ready=1.
6. Multiple rows low (keypadRow=0000) with key 4'b1111 held -> keypadCol=0111. keypadRow=1111 -> 1111.

Source files
------------

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared keypad types, idle column value and key-code field positions
package keypad_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESS_BOUNCE,
    HOLD,
    RELEASE_BOUNCE,
    DONE
  } state_e;

  localparam logic [3:0] KEYPAD_IDLE = 4'b1111;

  localparam int KEY_ROW_MSB = 3;
  localparam int KEY_ROW_LSB = 2;
  localparam int KEY_COL_MSB = 1;
  localparam int KEY_COL_LSB = 0;

  function automatic logic [1:0] key_row(input logic [3:0] key);
    return key[KEY_ROW_MSB:KEY_ROW_LSB];
  endfunction

  function automatic logic [1:0] key_col(input logic [3:0] key);
    return key[KEY_COL_MSB:KEY_COL_LSB];
  endfunction

endpackage

// File: rtl/keypad_matrix_responder_if.sv
// rtl/keypad_matrix_responder_if.sv - press-command handshake between a test driver and the responder
interface keypad_matrix_responder_if #(
  parameter int HOLD_W = 16
) ();
  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cmd_key;
  logic [HOLD_W-1:0] cmd_hold;
  logic              cmd_bounce;

  modport master (
    output cmd_valid, cmd_key, cmd_hold, cmd_bounce,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_key, cmd_hold, cmd_bounce,
    output cmd_ready
  );
endinterface

// File: rtl/keypad_bounce_gen.sv
// rtl/keypad_bounce_gen.sv - contact-bounce burst of 2*T phases of L cycles each
// level_o is the contact level for the cycle after the current edge, so the parent can register it.
module keypad_bounce_gen #(
  parameter int T = 4,
  parameter int L = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic polarity_i,
  output logic level_o,
  output logic finish_o
);

  localparam int PHASE_W = $clog2(2 * T);
  localparam int CYC_W   = (L > 1) ? $clog2(L) : 1;
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(2 * T - 1);
  localparam logic [CYC_W-1:0]   CYC_LAST   = CYC_W'(L - 1);

  logic               active_q, active_d;
  logic               pol_q, pol_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [CYC_W-1:0]   cyc_q, cyc_d;
  logic               phase_end;
  logic               last;

  assign phase_end = (cyc_q == CYC_LAST);
  assign last      = active_q && phase_end && (phase_q == PHASE_LAST);

  always_comb begin
    active_d = active_q;
    pol_d    = pol_q;
    phase_d  = phase_q;
    cyc_d    = cyc_q;
    if (start_i) begin
      active_d = 1'b1;
      pol_d    = polarity_i;
      phase_d  = '0;
      cyc_d    = '0;
    end else if (active_q) begin
      if (last) begin
        active_d = 1'b0;
        phase_d  = '0;
        cyc_d    = '0;
      end else if (phase_end) begin
        phase_d = phase_q + 1'b1;
        cyc_d   = '0;
      end else begin
        cyc_d = cyc_q + 1'b1;
      end
    end
  end

  // Press bursts close on even phases, release bursts on odd phases.
  assign level_o  = pol_d ? ~phase_d[0] : phase_d[0];
  assign finish_o = last;

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      pol_q    <= 1'b0;
      phase_q  <= '0;
      cyc_q    <= '0;
    end else begin
      active_q <= active_d;
      pol_q    <= pol_d;
      phase_q  <= phase_d;
      cyc_q    <= cyc_d;
    end
  end

endmodule

// File: rtl/keypad_matrix_responder.sv
// rtl/keypad_matrix_responder.sv - 4x4 keypad emulator answering row scans with column sense
import keypad_pkg::*;

module keypad_matrix_responder #(
  parameter int HOLD_W         = 16,
  parameter int BOUNCE_TOGGLES = 4,
  parameter int BOUNCE_LEN     = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  keypad_matrix_responder_if.slave   cmd,
  input  logic [3:0]                 keypadRow,
  output logic [3:0]                 keypadCol,
  output logic                       busy,
  output logic                       done,
  output logic                       contact
);

  state_e            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [3:0]        key_q, key_d;
  logic              bounce_q, bounce_d;
  logic              contact_q, contact_d;
  logic              bg_start, bg_pol, bg_level, bg_finish;
  logic              accept;

  keypad_bounce_gen #(
    .T (BOUNCE_TOGGLES),
    .L (BOUNCE_LEN)
  ) u_bounce (
    .clk        (clk),
    .rst        (rst),
    .start_i    (bg_start),
    .polarity_i (bg_pol),
    .level_o    (bg_level),
    .finish_o   (bg_finish)
  );

  assign cmd.cmd_ready = (state_q == IDLE);
  assign accept        = cmd.cmd_valid && (state_q == IDLE);

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    key_d    = key_q;
    bounce_d = bounce_q;
    bg_start = 1'b0;
    bg_pol   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          key_d    = cmd.cmd_key;
          bounce_d = cmd.cmd_bounce;
          // A zero hold still closes the contact for one cycle.
          hold_d   = (cmd.cmd_hold == '0) ? HOLD_W'(1) : cmd.cmd_hold;
          if (cmd.cmd_bounce) begin
            state_d  = PRESS_BOUNCE;
            bg_start = 1'b1;
            bg_pol   = 1'b1;
          end else begin
            state_d = HOLD;
          end
        end
      end
      PRESS_BOUNCE: begin
        if (bg_finish) state_d = HOLD;
      end
      HOLD: begin
        if (hold_q <= HOLD_W'(1)) begin
          if (bounce_q) begin
            state_d  = RELEASE_BOUNCE;
            bg_start = 1'b1;
          end else begin
            state_d = DONE;
          end
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      RELEASE_BOUNCE: begin
        if (bg_finish) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    contact_d = 1'b0;
    case (state_d)
      HOLD:                         contact_d = 1'b1;
      PRESS_BOUNCE, RELEASE_BOUNCE: contact_d = bg_level;
      default:                      contact_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      key_q     <= '0;
      bounce_q  <= 1'b0;
      contact_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      key_q     <= key_d;
      bounce_q  <= bounce_d;
      contact_q <= contact_d;
    end
  end

  always_comb begin
    keypadCol = KEYPAD_IDLE;
    if (contact_q && !keypadRow[key_row(key_q)]) begin
      keypadCol[key_col(key_q)] = 1'b0;
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign contact = contact_q;

endmodule

// File: tb/tb_keypad_matrix_responder.sv
// tb/tb_keypad_matrix_responder.sv - directed self-checking bench for keypad_matrix_responder
module tb_keypad_matrix_responder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] keypadRow = 4'b1111;
  logic [3:0] keypadCol;
  logic       busy, done, contact;
  int         checks = 0;
  int         errors = 0;
  logic [3:0] rows [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic       exp_c;

  keypad_matrix_responder_if #(.HOLD_W(16)) cmd_if ();

  keypad_matrix_responder #(
    .HOLD_W         (16),
    .BOUNCE_TOGGLES (4),
    .BOUNCE_LEN     (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd       (cmd_if),
    .keypadRow (keypadRow),
    .keypadCol (keypadCol),
    .busy      (busy),
    .done      (done),
    .contact   (contact)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    cmd_if.cmd_valid  = 1'b0;
    cmd_if.cmd_key    = 4'd0;
    cmd_if.cmd_hold   = 16'd0;
    cmd_if.cmd_bounce = 1'b0;

    // 1: reset and idle
    tick(); tick();
    rst = 1'b0;
    tick();
    for (int r = 0; r < 4; r++) begin
      keypadRow = rows[r];
      #1;
      chk("idle_col", keypadCol, 4'b1111);
    end
    chk("idle_ready", cmd_if.cmd_ready, 1'b1);
    chk("idle_busy", busy, 1'b0);
    chk("idle_done", done, 1'b0);
    chk("idle_contact", contact, 1'b0);

    // 2: key row1 col2, hold 5, no bounce
    cmd_if.cmd_key    = 4'b0110;
    cmd_if.cmd_hold   = 16'd5;
    cmd_if.cmd_bounce = 1'b0;
    cmd_if.cmd_valid  = 1'b1;
    tick();
    cmd_if.cmd_valid = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      chk("t2_contact", contact, 1'b1);
      chk("t2_busy", busy, 1'b1);
      chk("t2_done", done, 1'b0);
      for (int r = 0; r < 4; r++) begin
        keypadRow = rows[r];
        #1;
        chk("t2_col", keypadCol, (r == 1) ? 4'b1011 : 4'b1111);
      end
      tick();
    end
    chk("t2_done6", done, 1'b1);
    chk("t2_contact6", contact, 1'b0);
    chk("t2_ready6", cmd_if.cmd_ready, 1'b0);
    tick();
    chk("t2_ready7", cmd_if.cmd_ready, 1'b1);
    chk("t2_busy7", busy, 1'b0);
    chk("t2_done7", done, 1'b0);

    // 3: same key with bounce, 54 busy cycles
    cmd_if.cmd_bounce = 1'b1;
    cmd_if.cmd_valid  = 1'b1;
    keypadRow = 4'b1101;
    tick();
    cmd_if.cmd_valid = 1'b0;
    for (int c = 1; c <= 54; c++) begin
      if (c <= 24)      exp_c = (((c - 1) / 3) % 2) == 0;
      else if (c <= 29) exp_c = 1'b1;
      else if (c <= 53) exp_c = (((c - 30) / 3) % 2) == 1;
      else              exp_c = 1'b0;
      chk("t3_contact", contact, exp_c);
      chk("t3_col", keypadCol, exp_c ? 4'b1011 : 4'b1111);
      chk("t3_busy", busy, 1'b1);
      chk("t3_done", done, c == 54);
      tick();
    end
    chk("t3_busy_end", busy, 1'b0);
    chk("t3_ready_end", cmd_if.cmd_ready, 1'b1);

    // 4: zero hold, second command offered while busy
    cmd_if.cmd_key    = 4'b0110;
    cmd_if.cmd_hold   = 16'd0;
    cmd_if.cmd_bounce = 1'b0;
    cmd_if.cmd_valid  = 1'b1;
    tick();
    cmd_if.cmd_key  = 4'b1001;
    cmd_if.cmd_hold = 16'd2;
    chk("t4_contact1", contact, 1'b1);
    chk("t4_ready1", cmd_if.cmd_ready, 1'b0);
    tick();
    chk("t4_done2", done, 1'b1);
    chk("t4_contact2", contact, 1'b0);
    chk("t4_ready2", cmd_if.cmd_ready, 1'b0);
    tick();
    chk("t4_ready3", cmd_if.cmd_ready, 1'b1);
    chk("t4_busy3", busy, 1'b0);
    tick();
    cmd_if.cmd_valid = 1'b0;
    keypadRow = 4'b1011;
    #1;
    chk("t4_second_busy", busy, 1'b1);
    chk("t4_second_col", keypadCol, 4'b1101);
    tick();
    chk("t4_second_hold2", contact, 1'b1);
    tick();
    chk("t4_second_done", done, 1'b1);
    tick();
    chk("t4_second_idle", busy, 1'b0);

    // 5: reset in the middle of HOLD
    cmd_if.cmd_key   = 4'b0110;
    cmd_if.cmd_hold  = 16'd10;
    cmd_if.cmd_valid = 1'b1;
    tick();
    cmd_if.cmd_valid = 1'b0;
    tick();
    chk("t5_pre_contact", contact, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    keypadRow = 4'b1101;
    #1;
    chk("t5_contact", contact, 1'b0);
    chk("t5_col", keypadCol, 4'b1111);
    chk("t5_ready", cmd_if.cmd_ready, 1'b1);
    chk("t5_busy", busy, 1'b0);
    for (int c = 0; c < 12; c++) begin
      chk("t5_no_done", done, 1'b0);
      tick();
    end

    // 6: several rows low at once
    cmd_if.cmd_key   = 4'b1111;
    cmd_if.cmd_hold  = 16'd3;
    cmd_if.cmd_valid = 1'b1;
    tick();
    cmd_if.cmd_valid = 1'b0;
    keypadRow = 4'b0000;
    #1;
    chk("t6_all_low", keypadCol, 4'b0111);
    keypadRow = 4'b1111;
    #1;
    chk("t6_all_high", keypadCol, 4'b1111);
    keypadRow = 4'b0110;
    #1;
    chk("t6_row3_low", keypadCol, 4'b0111);
    keypadRow = 4'b1000;
    #1;
    chk("t6_row3_high", keypadCol, 4'b1111);
    tick(); tick(); tick();
    chk("t6_done", done, 1'b1);
    tick();
    chk("t6_idle", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
